conv_cfg_ctrl: RTL and testbench

Configuration controller for the convolution accelerator's control/status register file. Host writes land in a shadow register bank, and a start request commits the shadow bank atomically into the active bank. The controller then launches the convolution core and tracks it to completion. Double buffering lets the next layer's configuration be written while the current layer runs; one start request can be queued behind a running job.

---
 rtl/conv_cfg_ctrl_if.sv | 24 ++
 rtl/conv_cfg_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_conv_cfg_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_cfg_ctrl_if.sv
// Host-side bus of conv_cfg_ctrl: shadow-register writes, bank readback and start requests.
interface conv_cfg_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_bank;
    logic [DATA_W-1:0] rd_data;
    logic              start_req;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_addr, rd_bank, start_req,
        input  wr_ready, rd_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_addr, rd_bank, start_req,
        output wr_ready, rd_data
    );
endinterface

// File: rtl/conv_cfg_ctrl.sv
// Configuration controller for the convolution accelerator.
// Host writes fill a shadow bank; a start request commits it atomically to the
// active bank, launches the core and tracks it to completion. One start can be
// queued behind a running job.
// Optional watchdog: define CONV_CFG_WDOG_EN to abort a core that runs for
// TIMEOUT cycles without signalling done.
module conv_cfg_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned TIMEOUT  = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    conv_cfg_ctrl_if.slave               host,
    output logic                         core_start,
    input  logic                         core_done,
    output logic                         core_abort,
    output logic [NUM_REGS*DATA_W-1:0]   cfg_active,
    output logic                         busy,
    output logic                         done_irq,
    output logic                         pending,
    output logic                         err_ovf,
    output logic                         err_tmo,
    input  logic                         err_clr
);

    typedef enum logic [1:0] {IDLE, COMMIT, LAUNCH, RUN} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shadow_q [NUM_REGS];
    logic [DATA_W-1:0] shadow_d [NUM_REGS];
    logic [DATA_W-1:0] active_q [NUM_REGS];
    logic [DATA_W-1:0] active_d [NUM_REGS];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              pending_q, pending_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_tmo_q, err_tmo_d;
    logic              done_irq_q, done_irq_d;
    logic              core_start_q, core_start_d;
    logic              busy_q, busy_d;
    logic              wr_ready_q, wr_ready_d;
    logic              ovf_set;
    logic              wdog_exp;

`ifdef CONV_CFG_WDOG_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] wdog_q, wdog_d;

    // Expiry is decided in the same cycle so a coincident core_done can win.
    assign wdog_exp = (state_q == RUN) && !core_done && (wdog_q == CNT_W'(TIMEOUT - 1));

    // Watchdog counts RUN cycles; held at zero outside RUN so it restarts on entry.
    always_comb begin
        wdog_d = '0;
        if (state_q == RUN) begin
            wdog_d = wdog_q + CNT_W'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    // No watchdog: RUN waits for core_done indefinitely; TIMEOUT has no effect.
    if (TIMEOUT == 0) begin : g_no_wdog
    end
    assign wdog_exp = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, bank updates, start queueing, errors and registered outputs.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        err_ovf_d    = err_ovf_q;
        err_tmo_d    = err_tmo_q;
        ovf_set      = host.start_req && pending_q;

        unique case (state_q)
            IDLE:   if (host.start_req || pending_q) state_d = COMMIT;
            COMMIT: state_d = LAUNCH;
            LAUNCH: state_d = RUN;
            RUN: begin
                if (core_done) begin
                    state_d = (pending_q || host.start_req) ? COMMIT : IDLE;
                end else if (wdog_exp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (host.wr_valid && wr_ready_q) begin
            shadow_d[host.wr_addr] = host.wr_data;
        end
        if (state_q == COMMIT) begin
            active_d = shadow_q;
        end

        // A start during a job queues; entering COMMIT consumes the queued start.
        if (host.start_req && !pending_q && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end
        if ((state_d == COMMIT) && (state_q != COMMIT)) begin
            pending_d = 1'b0;
        end

        if (err_clr) begin
            err_ovf_d = 1'b0;
            err_tmo_d = 1'b0;
        end
        if (ovf_set) begin
            err_ovf_d = 1'b1;
        end
        if (wdog_exp) begin
            err_tmo_d = 1'b1;
        end

        done_irq_d   = (state_q == RUN) && core_done;
        core_start_d = (state_d == LAUNCH);
        busy_d       = (state_d != IDLE);
        wr_ready_d   = (state_d != COMMIT);
        rd_data_d    = host.rd_bank ? active_q[host.rd_addr] : shadow_q[host.rd_addr];
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q     <= '{default: '0};
            active_q     <= '{default: '0};
            rd_data_q    <= '0;
            pending_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_tmo_q    <= 1'b0;
            done_irq_q   <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            wr_ready_q   <= 1'b1;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            rd_data_q    <= rd_data_d;
            pending_q    <= pending_d;
            err_ovf_q    <= err_ovf_d;
            err_tmo_q    <= err_tmo_d;
            done_irq_q   <= done_irq_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            wr_ready_q   <= wr_ready_d;
        end
    end

    // Flatten the active bank: register k at bits [k*DATA_W +: DATA_W].
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_active
        assign cfg_active[k*DATA_W +: DATA_W] = active_q[k];
    end

    assign host.wr_ready = wr_ready_q;
    assign host.rd_data  = rd_data_q;
    assign core_start    = core_start_q;
    assign core_abort    = wdog_exp;
    assign busy          = busy_q;
    assign done_irq      = done_irq_q;
    assign pending       = pending_q;
    assign err_ovf       = err_ovf_q;
    assign err_tmo       = err_tmo_q;

endmodule

// File: tb/tb_conv_cfg_ctrl.sv
// Directed self-checking bench for conv_cfg_ctrl.
module tb_conv_cfg_ctrl;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned TIMEOUT  = 16;

    logic clk = 1'b0;
    logic rst;
    logic core_start, core_done, core_abort;
    logic busy, done_irq, pending, err_ovf, err_tmo, err_clr;
    logic [NUM_REGS*DATA_W-1:0] cfg_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_cfg_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) host ();

    conv_cfg_ctrl #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .host(host),
        .core_start(core_start), .core_done(core_done), .core_abort(core_abort),
        .cfg_active(cfg_active), .busy(busy), .done_irq(done_irq), .pending(pending),
        .err_ovf(err_ovf), .err_tmo(err_tmo), .err_clr(err_clr)
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        host.wr_valid = 1'b0; host.wr_addr = '0; host.wr_data = '0;
        host.rd_addr = '0; host.rd_bank = 1'b0; host.start_req = 1'b0;
        core_done = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, host.wr_ready, core_start, core_abort, done_irq, pending, err_ovf, err_tmo} !== 8'b0100_0000) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 01000000",
                     {busy, host.wr_ready, core_start, core_abort, done_irq, pending, err_ovf, err_tmo});
        end
        checks++;
        if (cfg_active !== '0 || host.rd_data !== '0) begin
            errors++;
            $display("FAIL reset_banks: cfg_active=%h rd_data=%h exp 0", cfg_active, host.rd_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_load();
        host.wr_valid = 1'b1; host.wr_addr = 3'd2; host.wr_data = 32'hDEADBEEF;
        host.rd_bank = 1'b0; host.rd_addr = 3'd2;
        tick();
        host.wr_valid = 1'b0;
        checks++;
        if (host.rd_data !== 32'h0) begin
            errors++; $display("FAIL shadow_rd_latency: got %h exp 00000000", host.rd_data);
        end
        tick();
        checks++;
        if (host.rd_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL shadow_rd: got %h exp deadbeef", host.rd_data);
        end
        host.rd_bank = 1'b1; host.start_req = 1'b1;
        tick();
        host.start_req = 1'b0;
        checks++;
        if ({busy, host.wr_ready, core_start} !== 3'b100 || host.rd_data !== 32'h0) begin
            errors++; $display("FAIL commit_cycle: busy/wr_ready/core_start=%b rd=%h exp 100 00000000",
                               {busy, host.wr_ready, core_start}, host.rd_data);
        end
        tick();
        checks++;
        if (core_start !== 1'b1 || host.wr_ready !== 1'b1 || cfg_active[2*DATA_W +: DATA_W] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL launch_cycle: core_start=%b wr_ready=%b active2=%h exp 1 1 deadbeef",
                               core_start, host.wr_ready, cfg_active[2*DATA_W +: DATA_W]);
        end
        checks++;
        if (host.rd_data !== 32'h0) begin
            errors++; $display("FAIL active_rd_before_launch: got %h exp 00000000", host.rd_data);
        end
        tick();
        checks++;
        if (core_start !== 1'b0 || busy !== 1'b1 || host.rd_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL run_entry: core_start=%b busy=%b rd=%h exp 0 1 deadbeef",
                               core_start, busy, host.rd_data);
        end
    endtask

    task automatic test_double_buffer();
        host.rd_bank = 1'b0; host.rd_addr = 3'd0;
        host.wr_valid = 1'b1; host.wr_addr = 3'd0; host.wr_data = 32'h5;
        checks++;
        if (host.wr_ready !== 1'b1) begin
            errors++; $display("FAIL wr_ready_run: got %b exp 1", host.wr_ready);
        end
        tick();
        host.wr_valid = 1'b0;
        tick();
        checks++;
        if (cfg_active[DATA_W-1:0] !== 32'h0 || host.rd_data !== 32'h5) begin
            errors++; $display("FAIL run_write_shadow_only: active0=%h shadow0=%h exp 0 5",
                               cfg_active[DATA_W-1:0], host.rd_data);
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if ({busy, done_irq} !== 2'b01) begin
            errors++; $display("FAIL done_to_idle: busy/done_irq=%b exp 01", {busy, done_irq});
        end
        tick();
        checks++;
        if (done_irq !== 1'b0 || cfg_active[DATA_W-1:0] !== 32'h0) begin
            errors++; $display("FAIL done_pulse_width: done_irq=%b active0=%h exp 0 0",
                               done_irq, cfg_active[DATA_W-1:0]);
        end
        host.start_req = 1'b1;
        tick();
        host.start_req = 1'b0;
        host.wr_valid = 1'b1; host.wr_addr = 3'd1; host.wr_data = 32'h77;
        checks++;
        if (host.wr_ready !== 1'b0) begin
            errors++; $display("FAIL wr_ready_commit: got %b exp 0", host.wr_ready);
        end
        tick();
        checks++;
        if (host.wr_ready !== 1'b1 || cfg_active[DATA_W-1:0] !== 32'h5 || cfg_active[DATA_W +: DATA_W] !== 32'h0) begin
            errors++; $display("FAIL second_commit: wr_ready=%b active0=%h active1=%h exp 1 5 0",
                               host.wr_ready, cfg_active[DATA_W-1:0], cfg_active[DATA_W +: DATA_W]);
        end
        tick();
        host.wr_valid = 1'b0; host.rd_addr = 3'd1;
        tick();
        checks++;
        if (host.rd_data !== 32'h77) begin
            errors++; $display("FAIL held_write_accepted: got %h exp 00000077", host.rd_data);
        end
    endtask

    task automatic test_queueing();
        int n_starts;
        host.start_req = 1'b1;
        tick();
        host.start_req = 1'b0;
        checks++;
        if ({pending, err_ovf, busy} !== 3'b101) begin
            errors++; $display("FAIL queue_first: pending/err_ovf/busy=%b exp 101", {pending, err_ovf, busy});
        end
        host.start_req = 1'b1;
        tick();
        host.start_req = 1'b0;
        checks++;
        if ({pending, err_ovf} !== 2'b11) begin
            errors++; $display("FAIL queue_overflow: pending/err_ovf=%b exp 11", {pending, err_ovf});
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if ({done_irq, busy, host.wr_ready, pending, core_start} !== 5'b11000) begin
            errors++; $display("FAIL queued_commit: done/busy/wr_ready/pending/core_start=%b exp 11000",
                               {done_irq, busy, host.wr_ready, pending, core_start});
        end
        n_starts = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (core_start === 1'b1) n_starts++;
        end
        checks++;
        if (n_starts !== 1 || done_irq !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL queued_launch_count: starts=%0d done_irq=%b busy=%b exp 1 0 1",
                               n_starts, done_irq, busy);
        end
    endtask

    task automatic test_error_clear();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_ovf !== 1'b0) begin
            errors++; $display("FAIL clr_alone_first: got %b exp 0", err_ovf);
        end
        host.start_req = 1'b1;
        tick();
        host.start_req = 1'b1; err_clr = 1'b1;
        tick();
        host.start_req = 1'b0; err_clr = 1'b0;
        checks++;
        if (err_ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_wins_over_clr: got %b exp 1", err_ovf);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if ({err_ovf, pending} !== 2'b01) begin
            errors++; $display("FAIL clr_after_ovf: err_ovf/pending=%b exp 01", {err_ovf, pending});
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        host.start_req = 1'b1; core_done = 1'b1;
        tick();
        host.start_req = 1'b0; core_done = 1'b0;
        checks++;
        if ({done_irq, busy, host.wr_ready, pending, err_ovf} !== 5'b11000) begin
            errors++; $display("FAIL start_with_done: done/busy/wr_ready/pending/err_ovf=%b exp 11000",
                               {done_irq, busy, host.wr_ready, pending, err_ovf});
        end
        tick();
        checks++;
        if (core_start !== 1'b1) begin
            errors++; $display("FAIL back_to_back_launch: got %b exp 1", core_start);
        end
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if ({busy, pending, done_irq} !== 3'b001) begin
            errors++; $display("FAIL back_to_back_idle: busy/pending/done=%b exp 001", {busy, pending, done_irq});
        end
        tick();
    endtask

    task automatic test_done_outside_run();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if ({done_irq, busy} !== 2'b00) begin
            errors++; $display("FAIL done_in_idle: done_irq/busy=%b exp 00", {done_irq, busy});
        end
    endtask

`ifdef CONV_CFG_WDOG_EN
    task automatic test_watchdog();
        int early;
        host.start_req = 1'b1;
        tick();
        host.start_req = 1'b0;
        tick();
        tick();
        early = 0;
        for (int i = 1; i < 16; i++) begin
            if (core_abort !== 1'b0) early++;
            tick();
        end
        checks++;
        if (early !== 0 || core_abort !== 1'b1 || err_tmo !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL wdog_expire: early=%0d abort=%b err_tmo=%b busy=%b exp 0 1 0 1",
                               early, core_abort, err_tmo, busy);
        end
        tick();
        checks++;
        if ({busy, err_tmo, core_abort, done_irq} !== 4'b0100) begin
            errors++; $display("FAIL wdog_after: busy/err_tmo/abort/done=%b exp 0100",
                               {busy, err_tmo, core_abort, done_irq});
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask
`else
    task automatic test_watchdog();
        int aborts;
        int idles;
        host.start_req = 1'b1;
        tick();
        host.start_req = 1'b0;
        tick();
        tick();
        aborts = 0;
        idles = 0;
        for (int i = 0; i < 40; i++) begin
            if (core_abort !== 1'b0) aborts++;
            if (busy !== 1'b1) idles++;
            tick();
        end
        checks++;
        if (aborts !== 0 || idles !== 0 || err_tmo !== 1'b0) begin
            errors++; $display("FAIL no_wdog_wait: aborts=%0d idles=%0d err_tmo=%b exp 0 0 0",
                               aborts, idles, err_tmo);
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if ({busy, done_irq} !== 2'b01) begin
            errors++; $display("FAIL no_wdog_done: busy/done_irq=%b exp 01", {busy, done_irq});
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        host.start_req = 1'b1;
        tick();
        host.start_req = 1'b0;
        tick();
        tick();
        host.start_req = 1'b1;
        tick();
        host.start_req = 1'b0;
        checks++;
        if ({busy, pending} !== 2'b11) begin
            errors++; $display("FAIL pre_reset_pending: busy/pending=%b exp 11", {busy, pending});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, host.wr_ready, core_start, core_abort, done_irq, pending, err_ovf, err_tmo} !== 8'b0100_0000
            || cfg_active !== '0 || host.rd_data !== '0) begin
            errors++; $display("FAIL reset_mid_run: flags=%b active_nz=%b rd=%h exp 01000000 0 0",
                               {busy, host.wr_ready, core_start, core_abort, done_irq, pending, err_ovf, err_tmo},
                               (cfg_active != '0), host.rd_data);
        end
        tick();
        rst = 1'b0;
        host.rd_bank = 1'b0; host.rd_addr = 3'd0;
        tick();
        checks++;
        if (host.rd_data !== 32'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_shadow0: rd=%h busy=%b exp 0 0", host.rd_data, busy);
        end
        host.rd_addr = 3'd1;
        tick();
        checks++;
        if (host.rd_data !== 32'h0) begin
            errors++; $display("FAIL reset_shadow1: got %h exp 00000000", host.rd_data);
        end
        host.rd_bank = 1'b1; host.rd_addr = 3'd2;
        tick();
        checks++;
        if (host.rd_data !== 32'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_active2: rd=%h busy=%b exp 0 0", host.rd_data, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_double_buffer();
        test_queueing();
        test_error_clear();
        test_back_to_back();
        test_done_outside_run();
        test_watchdog();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
